output_port_arbiter: RTL and testbench

//  Per-output-port arbiter/switch allocator: consumes the one-bit port requests that the five

---
 rtl/output_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_output_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// Per-output-port switch allocator: round-robin grant among five inputs with a wormhole lock
// held until the TAIL flit pops, plus credit-based flow control toward the downstream buffer.
`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b011
`endif

module output_port_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    req,
  input  logic [4:0]    empty,
  input  logic [14:0]   flit_id_in,
  input  logic          credit_in,
  output logic [4:0]    grant,
  output logic [2:0]    sel,
  output logic [4:0]    rd_en,
  output logic          valid_out,
  output logic [CW-1:0] credit_cnt,
  output logic          state_dbg
);

  // Handshake: rd_en[i] is the pop strobe; the input FIFO presents its next head flit the
  // cycle after a pop, and valid_out marks the popped flit one cycle after rd_en.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [4:0]    grant_q, grant_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          valid_q;

  logic [2:0]    head_id [5];
  logic [4:0]    eligible;
  logic          found;
  logic [2:0]    winner;
  logic [3:0]    scan;
  logic          credit_ok;
  logic          pop;
  logic          tail_pop;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      head_id[i]  = flit_id_in[3*i +: 3];
      eligible[i] = req[i] & ~empty[i] & (head_id[i] == `HEADER);
    end
  end

  // Scan starts one past the last winner so the previous owner has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    scan   = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      scan = {1'b0, rr_ptr_q} + 4'(k);
      if (scan >= 4'd5) scan = scan - 4'd5;
      if (!found && eligible[scan[2:0]]) begin
        found  = 1'b1;
        winner = scan[2:0];
      end
    end
  end

  assign credit_ok = (credit_q != '0);
  assign rd_en     = (state_q == LOCK && credit_ok) ? (grant_q & ~empty) : 5'b0;
  assign pop       = |rd_en;
  assign tail_pop  = pop && (head_id[sel_q] == `TAIL);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = LOCK;
          grant_d  = 5'(1) << winner;
          sel_d    = winner;
          rr_ptr_d = winner;
        end else begin
          grant_d = 5'b0;
          sel_d   = 3'd0;
        end
      end
      LOCK: begin
        if (tail_pop) begin
          state_d = IDLE;
          grant_d = 5'b0;
          sel_d   = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop and a returned credit in the same cycle cancel; a credit beyond DEPTH is dropped.
  always_comb begin
    credit_d = credit_q;
    if (pop && !credit_in)
      credit_d = credit_q - CW'(1);
    else if (!pop && credit_in && credit_q != DEPTH_C)
      credit_d = credit_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= 5'b0;
      sel_q    <= 3'd0;
      rr_ptr_q <= 3'd4;
      credit_q <= DEPTH_C;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      valid_q  <= pop;
    end
  end

  assign grant      = grant_q;
  assign sel        = sel_q;
  assign valid_out  = valid_q;
  assign credit_cnt = credit_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: models the five input FIFOs as flit queues, predicts the grant
// order in a scoreboard and tracks credits/valid_out cycle by cycle.
`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b011
`endif

module tb_output_port_arbiter;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic [4:0]    req;
  logic [4:0]    empty;
  logic [14:0]   flit_id_in;
  logic          credit_in;
  logic [4:0]    grant;
  logic [2:0]    sel;
  logic [4:0]    rd_en;
  logic          valid_out;
  logic [CW-1:0] credit_cnt;
  logic          state_dbg;

  output_port_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .empty      (empty),
    .flit_id_in (flit_id_in),
    .credit_in  (credit_in),
    .grant      (grant),
    .sel        (sel),
    .rd_en      (rd_en),
    .valid_out  (valid_out),
    .credit_cnt (credit_cnt),
    .state_dbg  (state_dbg)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] exp_q [$];
  logic [2:0] fq [5][$];
  logic [4:0] hold_empty;
  logic       auto_credit;
  logic       mon_en;
  int         crd_model;
  logic [4:0] grant_prev;
  int         pop_cnt [5];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 5; i++) begin
      empty[i] = (fq[i].size() == 0) || hold_empty[i];
      flit_id_in[3*i +: 3] = (fq[i].size() != 0) ? fq[i][0] : `PAYLOAD;
    end
    #1;
  endtask

  task automatic step();
    logic [4:0] rd_snap;
    logic       cin_snap;
    logic [2:0] e;
    rd_snap  = rd_en;
    cin_snap = credit_in;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (rd_snap[i]) begin
        pop_cnt[i]++;
        if (fq[i].size() != 0) void'(fq[i].pop_front());
      end
    end
    if (mon_en) begin
      check("valid_out_lag", {31'b0, valid_out}, {31'b0, |rd_snap});
      if (|rd_snap && !cin_snap) crd_model--;
      else if (!(|rd_snap) && cin_snap && crd_model < DEPTH) crd_model++;
      check("credit_cnt", 32'(credit_cnt), crd_model);
      check("rd_en_in_grant", {27'b0, rd_en & ~grant}, 32'd0);
      if (grant_prev == 5'b0 && grant != 5'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", {27'b0, grant}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("grant_sel", {29'b0, sel}, {29'b0, e});
          check("grant_onehot", {27'b0, grant}, {27'b0, 5'(1) << e});
        end
      end
    end
    grant_prev = grant;
    if (auto_credit) credit_in = |rd_snap;
    drive_inputs();
  endtask

  task automatic give_credits(input int n);
    for (int k = 0; k < n; k++) begin
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
    end
  endtask

  function automatic bit busy();
    bit b;
    b = (grant != 5'b0) || state_dbg;
    for (int i = 0; i < 5; i++) if (fq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input int max);
    int n;
    n = 0;
    while (busy() && n < max) begin
      step();
      n++;
    end
    if (busy()) check("drain_timeout", 32'd1, 32'd0);
    check("exp_q_empty", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    mon_en      = 1'b0;
    rst         = 1'b0;
    req         = 5'b0;
    credit_in   = 1'b0;
    hold_empty  = 5'b0;
    auto_credit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fq[i].delete();
      pop_cnt[i] = 0;
    end
    exp_q.delete();
    drive_inputs();
    step();
    step();
    rst        = 1'b1;
    crd_model  = DEPTH;
    grant_prev = 5'b0;
    mon_en     = 1'b1;
    #1;
  endtask

  task automatic push_pkt(input int i, input int len);
    fq[i].push_back(`HEADER);
    for (int k = 0; k < len - 2; k++) fq[i].push_back(`PAYLOAD);
    fq[i].push_back(`TAIL);
  endtask

  initial begin
    rst = 1'b1; req = 5'b0; credit_in = 1'b0; hold_empty = 5'b0;
    auto_credit = 1'b0; mon_en = 1'b0; grant_prev = 5'b0; crd_model = DEPTH;
    for (int i = 0; i < 5; i++) pop_cnt[i] = 0;
    drive_inputs();

    // 1: reset values
    rst = 1'b0;
    #1;
    check("rst_grant", {27'b0, grant}, 32'd0);
    check("rst_sel", {29'b0, sel}, 32'd0);
    check("rst_rd_en", {27'b0, rd_en}, 32'd0);
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_credit", 32'(credit_cnt), DEPTH);
    check("rst_state", {31'b0, state_dbg}, 32'd0);
    do_reset();

    // 2: single 3-flit packet on input 1
    push_pkt(1, 3);
    req = 5'b00010;
    exp_q.push_back(3'd1);
    drive_inputs();
    check("t2_pre_grant", {27'b0, grant}, 32'd0);
    step();
    check("t2_grant", {27'b0, grant}, 32'b00010);
    check("t2_sel", {29'b0, sel}, 32'd1);
    check("t2_rd_en_a", {27'b0, rd_en}, 32'b00010);
    check("t2_valid_a", {31'b0, valid_out}, 32'd0);
    step();
    check("t2_rd_en_b", {27'b0, rd_en}, 32'b00010);
    check("t2_valid_b", {31'b0, valid_out}, 32'd1);
    step();
    check("t2_rd_en_c", {27'b0, rd_en}, 32'b00010);
    step();
    check("t2_grant_clear", {27'b0, grant}, 32'd0);
    check("t2_rd_en_off", {27'b0, rd_en}, 32'd0);
    check("t2_valid_c", {31'b0, valid_out}, 32'd1);
    check("t2_pops", pop_cnt[1], 32'd3);
    req = 5'b0;
    step();
    check("t2_valid_d", {31'b0, valid_out}, 32'd0);
    check("t2_state_idle", {31'b0, state_dbg}, 32'd0);

    // 3: round robin across inputs 0, 2, 4
    do_reset();
    auto_credit = 1'b1;
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 2);
      push_pkt(2, 2);
      push_pkt(4, 2);
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd4);
    end
    req = 5'b10101;
    drive_inputs();
    drain(200);
    check("t3_pops0", pop_cnt[0], 32'd6);
    check("t3_pops2", pop_cnt[2], 32'd6);
    check("t3_pops4", pop_cnt[4], 32'd6);

    // 4: credit exhaustion on a 6-flit packet with a HEADER in its body
    do_reset();
    fq[3].push_back(`HEADER);  fq[3].push_back(`PAYLOAD);
    fq[3].push_back(`HEADER);  fq[3].push_back(`PAYLOAD);
    fq[3].push_back(`PAYLOAD); fq[3].push_back(`TAIL);
    req = 5'b01000;
    exp_q.push_back(3'd3);
    drive_inputs();
    repeat (12) step();
    check("t4_pops_4", pop_cnt[3], 32'd4);
    check("t4_grant_held", {27'b0, grant}, 32'b01000);
    check("t4_credit0", 32'(credit_cnt), 32'd0);
    check("t4_rd_en_stall", {27'b0, rd_en}, 32'd0);
    check("t4_locked", {31'b0, state_dbg}, 32'd1);
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    check("t4_credit1", 32'(credit_cnt), 32'd1);
    repeat (5) step();
    check("t4_pops_5", pop_cnt[3], 32'd5);
    check("t4_credit0_again", 32'(credit_cnt), 32'd0);
    check("t4_grant_still", {27'b0, grant}, 32'b01000);
    req = 5'b0;
    give_credits(4);
    drain(50);
    check("t4_pops_6", pop_cnt[3], 32'd6);

    // 5: simultaneous pop and credit, then saturation
    do_reset();
    push_pkt(2, 5);
    req = 5'b00100;
    exp_q.push_back(3'd2);
    drive_inputs();
    step();
    step();
    step();
    check("t5_credit2", 32'(credit_cnt), 32'd2);
    check("t5_rd_en", {27'b0, rd_en}, 32'b00100);
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    check("t5_pop_and_credit", 32'(credit_cnt), 32'd2);
    check("t5_pops", pop_cnt[2], 32'd3);
    req = 5'b0;
    drain(20);
    check("t5_credit_drained", 32'(credit_cnt), 32'd0);
    give_credits(5);
    check("t5_saturate", 32'(credit_cnt), 32'd4);

    // 6: stalled lock on input 4, competing request, async reset mid-packet
    do_reset();
    push_pkt(4, 4);
    req = 5'b10000;
    exp_q.push_back(3'd4);
    drive_inputs();
    step();
    check("t6_grant", {27'b0, grant}, 32'b10000);
    hold_empty[4] = 1'b1;
    push_pkt(0, 2);
    req = 5'b10001;
    drive_inputs();
    check("t6_rd_en_gated", {27'b0, rd_en}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_stall_rd_en", {27'b0, rd_en}, 32'd0);
      check("t6_stall_grant", {27'b0, grant}, 32'b10000);
      check("t6_stall_sel", {29'b0, sel}, 32'd4);
    end
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_rst_grant", {27'b0, grant}, 32'd0);
    check("t6_rst_sel", {29'b0, sel}, 32'd0);
    check("t6_rst_rd_en", {27'b0, rd_en}, 32'd0);
    check("t6_rst_valid", {31'b0, valid_out}, 32'd0);
    check("t6_rst_credit", 32'(credit_cnt), DEPTH);
    check("t6_rst_state", {31'b0, state_dbg}, 32'd0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
